// File: rtl/arm_ctrl_seq_if.sv
// Control bundle between the ARM fetch/decode/execute sequencer and the datapath/ROM side.
// The sequencer takes the slave view; the datapath/ROM side takes the master view.
interface arm_ctrl_seq_if;
  logic        run;
  logic        eint;
  logic [7:0]  PC;
  logic [15:0] instr;
  logic        CEENZ;
  logic [5:0]  calu;
  logic [1:0]  cpc;
  logic [1:0]  csrc;
  logic [2:0]  cmsrc;
  logic        wr_en;
  logic [5:0]  addr;
  logic [7:0]  Lit;
  logic        call;
  logic        ret;
  logic        push;
  logic        pop;
  logic        in_isr;
  logic        halted;
  logic [2:0]  state;

  // PC addresses the ROM directly on the datapath side, so the sequencer never reads it.
  modport master (
    output run, eint, PC, instr, CEENZ,
    input  calu, cpc, csrc, cmsrc, wr_en, addr, Lit, call, ret, push, pop, in_isr, halted, state
  );

  modport slave (
    input  run, eint, instr, CEENZ,
    output calu, cpc, csrc, cmsrc, wr_en, addr, Lit, call, ret, push, pop, in_isr, halted, state
  );
endinterface

// File: rtl/arm_ctrl_seq.sv
// Multi-cycle fetch/decode/execute sequencer driving the ARM datapath controls,
// with a synchronised, non-nesting vectored interrupt taken at instruction boundaries.
module arm_ctrl_seq #(
  parameter logic [7:0]  IRQ_VEC     = 8'hF0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  arm_ctrl_seq_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    IRQ    = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic [5:0] calu;
    logic [1:0] cpc;
    logic [1:0] csrc;
    logic [2:0] cmsrc;
    logic       wr_en;
    logic [5:0] addr;
    logic [7:0] lit;
    logic       call;
    logic       ret;
    logic       push;
    logic       pop;
  } ctl_t;

  state_t                 state_q, state_d;
  ctl_t                   ctl_q, ctl_d;
  logic [15:0]            ir_q, ir_d;
  logic                   pending_q, pending_d;
  logic                   in_isr_q, in_isr_d;
  logic                   halted_q, halted_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   eint_rise;
  logic                   take_irq;
  logic [1:0]             cls;
  logic [5:0]             fn;
  logic [7:0]             imm;
  logic                   is_halt;

  assign cls       = ir_q[15:14];
  assign fn        = ir_q[13:8];
  assign imm       = ir_q[7:0];
  assign is_halt   = (cls == 2'b10) && (fn == 6'h3F);
  assign eint_rise = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.eint};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Controls are computed one state early so the registered outputs line up with EXEC/IRQ.
  always_comb begin
    state_d  = state_q;
    ctl_d    = '0;
    ir_d     = ir_q;
    take_irq = 1'b0;
    case (state_q)
      IDLE: if (bus.run) state_d = FETCH;
      FETCH: begin
        if (pending_q && !in_isr_q) begin
          state_d   = IRQ;
          take_irq  = 1'b1;
          ctl_d.call = 1'b1;
          ctl_d.cpc  = 2'b10;
          ctl_d.lit  = IRQ_VEC;
        end else begin
          ir_d    = bus.instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = EXEC;
        case (cls)
          2'b00: begin
            ctl_d.calu = fn;
            ctl_d.lit  = imm;
            ctl_d.csrc = 2'b01;
            ctl_d.cpc  = 2'b01;
          end
          2'b01: begin
            ctl_d.cmsrc = fn[2:0];
            ctl_d.cpc   = 2'b01;
            if (fn[5]) begin
              ctl_d.wr_en = 1'b1;
              ctl_d.addr  = imm[5:0];
            end else begin
              ctl_d.csrc = 2'b10;
            end
          end
          2'b10: begin
            ctl_d.lit = imm;
            if (!is_halt) begin
              case (fn[1:0])
                2'b00: ctl_d.cpc = 2'b10;
                2'b01: ctl_d.cpc = bus.CEENZ ? 2'b01 : 2'b10;
                2'b10: begin
                  ctl_d.call = 1'b1;
                  ctl_d.cpc  = 2'b10;
                end
                default: ctl_d.ret = 1'b1;
              endcase
            end
          end
          default: begin
            ctl_d.cpc = 2'b01;
            if (fn[0]) begin
              ctl_d.pop = 1'b1;
            end else begin
              ctl_d.push  = 1'b1;
              ctl_d.cmsrc = fn[2:0];
            end
          end
        endcase
      end
      EXEC:    state_d = is_halt ? HALT : FETCH;
      IRQ:     state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    // A new edge wins over the clear so an edge landing on the IRQ entry is held.
    pending_d = eint_rise | (pending_q & ~take_irq);
    in_isr_d  = take_irq | (in_isr_q & ~ctl_d.ret);
    halted_d  = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ctl_q     <= '0;
      ir_q      <= '0;
      pending_q <= 1'b0;
      in_isr_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctl_q     <= ctl_d;
      ir_q      <= ir_d;
      pending_q <= pending_d;
      in_isr_q  <= in_isr_d;
      halted_q  <= halted_d;
    end
  end

  assign bus.calu   = ctl_q.calu;
  assign bus.cpc    = ctl_q.cpc;
  assign bus.csrc   = ctl_q.csrc;
  assign bus.cmsrc  = ctl_q.cmsrc;
  assign bus.wr_en  = ctl_q.wr_en;
  assign bus.addr   = ctl_q.addr;
  assign bus.Lit    = ctl_q.lit;
  assign bus.call   = ctl_q.call;
  assign bus.ret    = ctl_q.ret;
  assign bus.push   = ctl_q.push;
  assign bus.pop    = ctl_q.pop;
  assign bus.in_isr = in_isr_q;
  assign bus.halted = halted_q;
  assign bus.state  = state_q;
endmodule

// File: tb/tb_arm_ctrl_seq.sv
// Scoreboard bench for arm_ctrl_seq: directed instructions push expected EXEC/IRQ controls,
// a negedge monitor pops and compares them whenever the sequencer presents outputs.
module tb_arm_ctrl_seq;
  logic clk = 1'b0;
  logic rst;
  arm_ctrl_seq_if bus ();

  arm_ctrl_seq #(.IRQ_VEC(8'hF0), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [33:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic done    = 1'b0;

  function automatic logic [33:0] mk(input logic [5:0] calu, input logic [1:0] cpc,
                                     input logic [1:0] csrc, input logic [2:0] cmsrc,
                                     input logic wr, input logic [5:0] addr, input logic [7:0] lit,
                                     input logic call, input logic ret, input logic push,
                                     input logic pop, input logic isr);
    return {calu, cpc, csrc, cmsrc, wr, addr, lit, call, ret, push, pop, isr, 1'b0};
  endfunction

  function automatic logic [33:0] observe();
    return {bus.calu, bus.cpc, bus.csrc, bus.cmsrc, bus.wr_en, bus.addr, bus.Lit,
            bus.call, bus.ret, bus.push, bus.pop, bus.in_isr, bus.halted};
  endfunction

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: EXEC/IRQ cycles consume one scoreboard entry; every other cycle must be quiet.
  always @(negedge clk) begin
    if (rst === 1'b0 && !done) begin
      if (bus.state == 3'd3 || bus.state == 3'd4) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output state=%0d got=%h expected=none", bus.state, observe());
        end else begin
          exp_t e;
          e = sb.pop_front();
          check(e.name, observe(), e.v);
        end
      end else begin
        check("quiet", {25'd0, bus.wr_en, bus.call, bus.ret, bus.push, bus.pop, bus.cpc, bus.csrc},
              34'd0);
      end
    end
  end

  task automatic wait_state(input logic [2:0] s, input string what);
    int k = 0;
    while (bus.state !== s && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (bus.state !== s) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_%s got_state=%0d expected_state=%0d", what, bus.state, s);
    end
  endtask

  task automatic issue(input logic [15:0] ins, input string name, input logic [33:0] e);
    wait_state(3'd1, name);
    bus.instr = ins;
    sb.push_back('{name, e});
    @(negedge clk);
  endtask

  task automatic expect_irq(input string name);
    wait_state(3'd1, name);
    sb.push_back('{name, mk(6'h00, 2'b10, 2'b00, 3'b000, 1'b0, 6'h00, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1)});
    @(negedge clk);
  endtask

  logic [33:0] e_alu, e_alu_isr, e_ret;

  initial begin
    e_alu     = mk(6'h05, 2'b01, 2'b01, 3'b000, 1'b0, 6'h00, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_alu_isr = mk(6'h05, 2'b01, 2'b01, 3'b000, 1'b0, 6'h00, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e_ret     = mk(6'h00, 2'b00, 2'b00, 3'b000, 1'b0, 6'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    rst       = 1'b1;
    bus.run   = 1'b0;
    bus.eint  = 1'b0;
    bus.PC    = 8'h00;
    bus.instr = 16'h0000;
    bus.CEENZ = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", observe(), 34'd0);
    check("reset_state", {31'd0, bus.state}, 34'd0);
    rst = 1'b0;
    @(negedge clk);

    bus.run = 1'b1;
    issue(16'h0512, "alu_0512_a", e_alu);
    issue(16'h0512, "alu_0512_b", e_alu);
    issue(16'h6303, "store_6303", mk(6'h00, 2'b01, 2'b00, 3'b011, 1'b1, 6'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(16'h4205, "load_4205", mk(6'h00, 2'b01, 2'b10, 3'b010, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.CEENZ = 1'b0;
    issue(16'h8144, "jz_taken", mk(6'h00, 2'b10, 2'b00, 3'b000, 1'b0, 6'h00, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_state(3'd1, "ceenz_set");
    bus.CEENZ = 1'b1;
    issue(16'h8144, "jz_not_taken", mk(6'h00, 2'b01, 2'b00, 3'b000, 1'b0, 6'h00, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_state(3'd1, "ceenz_clr");
    bus.CEENZ = 1'b0;
    issue(16'h8022, "jmp_8022", mk(6'h00, 2'b10, 2'b00, 3'b000, 1'b0, 6'h00, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(16'h8233, "call_8233", mk(6'h00, 2'b10, 2'b00, 3'b000, 1'b0, 6'h00, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(16'hC206, "push_c206", mk(6'h00, 2'b01, 2'b00, 3'b010, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    issue(16'hC105, "pop_c105", mk(6'h00, 2'b01, 2'b00, 3'b000, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

    // eint high FETCH..EXEC of an ALU op: pending lands at that EXEC->FETCH edge.
    wait_state(3'd1, "irq1_alu");
    bus.eint = 1'b1;
    issue(16'h0512, "alu_before_irq", e_alu);
    @(negedge clk);
    bus.eint = 1'b0;
    expect_irq("irq_first");

    // Second edge inside the ISR must wait for RET.
    wait_state(3'd1, "irq2_alu");
    bus.eint = 1'b1;
    issue(16'h0512, "alu_in_isr", e_alu_isr);
    @(negedge clk);
    bus.eint = 1'b0;
    issue(16'h8300, "ret_first", e_ret);
    expect_irq("irq_after_ret");
    issue(16'h8300, "ret_second", e_ret);
    issue(16'h0512, "alu_after_isr", e_alu);

    // Reset in the middle of a store's EXEC cycle.
    issue(16'h6303, "store_before_rst", mk(6'h00, 2'b01, 2'b00, 3'b011, 1'b1, 6'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_state(3'd3, "store_exec");
    #2 rst = 1'b1;
    #1;
    check("rst_mid_exec_outputs", observe(), 34'd0);
    check("rst_mid_exec_state", {31'd0, bus.state}, 34'd0);
    bus.run = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    bus.run = 1'b1;
    @(negedge clk);
    check("fetch_after_rst", {31'd0, bus.state}, 34'd1);
    issue(16'h0512, "alu_after_rst", e_alu);

    issue(16'hBF00, "halt_exec", 34'd0);
    wait_state(3'd5, "halt_enter");
    for (int i = 0; i < 8; i++) begin
      bus.run  = i[0];
      bus.eint = i[1];
      @(negedge clk);
      check("halt_sticky", {28'd0, bus.state, bus.halted, bus.cpc, bus.in_isr}, {28'd0, 3'd5, 1'b1, 2'b00, 1'b0});
    end

    done = 1'b1;
    check("scoreboard_empty", 34'(sb.size()), 34'd0);
    rst = 1'b1;
    #1;
    check("rst_clears_halt", {31'd0, bus.state, bus.halted}, 34'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
